// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
//
// Host-side driver for a layer's serial configuration chain. Parallel words
// arrive from the host over a valid/ready handshake and are shifted onto the
// chain MSB-first, word 0 first. An optional second (verify) pass re-shifts
// the same CFG_LEN bits. During that pass the bits falling out of the chain
// tail are compared with the bits going in. A full pass pushes the original
// contents back out, so matching bits confirm the chain held what was written.
//
// Handshake: a word transfers on every rising edge where wr_valid && wr_ready.
// wr_ready depends only on the state (high in LOAD). wr_data is sampled only
// on that edge. The host may hold wr_valid low for as long as it likes.
//
// Ports
//   clk       in   single clock, rising edge
//   rstb      in   asynchronous active-low reset
//   start     in   one-cycle pulse that begins a load (ignored while busy)
//   verify    in   sampled with start: 1 = load + verify pass, 0 = load only
//   abort     in   synchronous abort back to IDLE (no done pulse)
//   wr_valid  in   host word valid
//   wr_ready  out  block can accept a host word (LOAD state)
//   wr_data   in   host word, WORD_WIDTH bits
//   busy      out  high while a load is in progress
//   done      out  one-cycle pulse on normal completion
//   err       out  sticky verify mismatch flag, cleared by an accepted start
//   err_cnt   out  saturating verify mismatch count, cleared by accepted start
//   cfg_we    out  chain shift enable (registered)
//   cfg_d     out  chain serial data (registered)
//   cfg_q     in   chain tail (registered output of the last stage)
//   dbg_state out  current FSM state encoding (IDLE=0, LOAD=1, SHIFT=2)
// -----------------------------------------------------------------------------
module cfg_loader #(
  parameter int CFG_LEN    = 128,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic                  verify,
  input  logic                  abort,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            err_cnt,
  output logic                  cfg_we,
  output logic                  cfg_d,
  input  logic                  cfg_q,
  output logic [1:0]            dbg_state
);

  localparam int NUM_WORDS = CFG_LEN / WORD_WIDTH;
  localparam int WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BCW       = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Pass bookkeeping
  logic           pass_q;     // 0 = load pass, 1 = verify pass
  logic           verify_q;   // verify request latched at start
  logic [WCW-1:0] word_cnt;
  logic [BCW-1:0] bit_cnt;

  // The MSB goes straight to cfg_d at the handshake, so only the remaining
  // WORD_WIDTH-1 bits need to be held for shifting.
  logic [WORD_WIDTH-2:0] shreg;

  // Decoded actions for the current cycle
  logic start_acc;   // start accepted in IDLE
  logic hs;          // host word transfer
  logic shift_bit;   // present the next lower bit on cfg_d
  logic last_bit;    // final bit of the word is on the chain this cycle
  logic next_pass;   // load pass complete, verify pass follows
  logic finish;      // normal completion
  logic abort_now;   // abort taken (only outside IDLE)
  logic mismatch;    // verify compare failure on this edge

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    hs        = 1'b0;
    shift_bit = 1'b0;
    last_bit  = 1'b0;
    next_pass = 1'b0;
    finish    = 1'b0;
    abort_now = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort is meaningless here, so a coincident start still wins
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          abort_now = 1'b1;
          state_d   = ST_IDLE;
        end else if (wr_valid) begin
          hs      = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          abort_now = 1'b1;
          state_d   = ST_IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          last_bit = 1'b1;
          if (word_cnt == LAST_WORD) begin
            if (!pass_q && verify_q) begin
              next_pass = 1'b1;
              state_d   = ST_LOAD;
            end else begin
              finish  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          shift_bit = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Compare the bit leaving the chain tail against the bit entering it.
  // The abort edge is excluded so an abort never alters the error status.
  assign mismatch = cfg_we && pass_q && !abort_now && (cfg_q != cfg_d);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pass_q   <= 1'b0;
      verify_q <= 1'b0;
      word_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cfg_we   <= 1'b0;
      cfg_d    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      done <= finish;

      if (mismatch) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      if (start_acc) begin
        pass_q   <= 1'b0;
        verify_q <= verify;
        word_cnt <= '0;
        bit_cnt  <= '0;
        err      <= 1'b0;
        err_cnt  <= 8'd0;
      end

      if (hs) begin
        shreg   <= wr_data[WORD_WIDTH-2:0];
        cfg_we  <= 1'b1;
        cfg_d   <= wr_data[WORD_WIDTH-1];
        bit_cnt <= '0;
      end

      if (shift_bit) begin
        cfg_d   <= shreg[WORD_WIDTH-2];
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + BCW'(1);
      end

      if (last_bit) begin
        cfg_we   <= 1'b0;
        bit_cnt  <= '0;
        word_cnt <= word_cnt + WCW'(1);
        if (next_pass) begin
          pass_q   <= 1'b1;
          word_cnt <= '0;
        end
      end

      // Chain is left exactly as far as it was shifted; only the enable drops.
      if (abort_now) begin
        cfg_we <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State-derived outputs
  // ---------------------------------------------------------------------------
  assign wr_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader
//
// Directed bench for cfg_loader with a behavioural 128-stage chain hanging off
// cfg_we/cfg_d/cfg_q. Words sent by the driver are queued as expected words;
// a monitor reassembles the serial stream into observed words.
// -----------------------------------------------------------------------------
module tb_cfg_loader;

  localparam int CFG_LEN = 128;
  localparam int W       = 16;
  localparam int NW      = CFG_LEN / W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk  = 1'b0;
  logic rstb = 1'b0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic         start    = 1'b0;
  logic         verify   = 1'b0;
  logic         abort    = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data  = '0;
  logic         wr_ready;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   err_cnt;
  logic         cfg_we;
  logic         cfg_d;
  logic         cfg_q;
  logic [1:0]   dbg_state;

  cfg_loader #(
    .CFG_LEN   (CFG_LEN),
    .WORD_WIDTH(W)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .start    (start),
    .verify   (verify),
    .abort    (abort),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_cnt  (err_cnt),
    .cfg_we   (cfg_we),
    .cfg_d    (cfg_d),
    .cfg_q    (cfg_q),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Chain model: shifts on every edge with cfg_we high, tail is the last stage
  // ---------------------------------------------------------------------------
  logic [CFG_LEN-1:0] chain = '0;

  assign cfg_q = chain[CFG_LEN-1];

  always @(posedge clk) begin
    if (cfg_we) begin
      chain <= {chain[CFG_LEN-2:0], cfg_d};
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: expected words from the driver, observed words from the wire
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] mon_acc  = '0;
  int           mon_bits = 0;

  // A partial word (cut short by abort or reset) is dropped once cfg_we falls.
  always @(posedge clk) begin
    if (cfg_we) begin
      if (mon_bits == W - 1) begin
        obs_q.push_back({mon_acc[W-2:0], cfg_d});
        mon_bits <= 0;
      end else begin
        mon_bits <= mon_bits + 1;
      end
      mon_acc <= {mon_acc[W-2:0], cfg_d};
    end else begin
      mon_bits <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain_sb();
    while (obs_q.size() > 0) begin
      logic [W-1:0] o;
      o = obs_q.pop_front();
      if (exp_q.size() > 0) begin
        check("sb_word", o, exp_q.pop_front());
      end else begin
        check("sb_extra_words", obs_q.size() + 1, 0);
        obs_q.delete();
      end
    end
    check("sb_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus data
  //   mode 0: both passes A5F0+i
  //   mode 1: verify-pass word 3 has bit 0 flipped
  //   mode 2: verify-pass data fully inverted
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] word_val(input int p, input int i, input int mode);
    logic [W-1:0] v;
    v = 16'hA5F0 + 16'(i);
    if (p == 1 && mode == 1 && i == 3) v[0] = ~v[0];
    if (p == 1 && mode == 2) v = ~v;
    return v;
  endfunction

  // Chain image after a complete pass: word 0 ends up in the top (tail) bits.
  function automatic logic [CFG_LEN-1:0] chain_img(input int p, input int mode);
    logic [CFG_LEN-1:0] img;
    img = '0;
    for (int i = 0; i < NW; i++) begin
      img = {img[CFG_LEN-W-1:0], word_val(p, i, mode)};
    end
    return img;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one complete load (optionally with verify pass), cycle by cycle.
  //   gap        : hold wr_valid low 5 ready cycles before word 3
  //   with_abort : raise abort together with start (start must win in IDLE)
  //   kill_w     : >=0 kills the run on the 8th shifted bit of that word
  //   kill_rst   : kill by asynchronous reset instead of abort
  // done_cyc counts cycles from the start edge; -1 if no done was seen.
  // ---------------------------------------------------------------------------
  task automatic run_load(input bit vfy, input int mode, input bit gap, input bit with_abort,
                          input int kill_w, input bit kill_rst,
                          output int done_cyc, output int we_cyc);
    int c;
    int w;
    int wb;
    int gap_left;
    int nwords;
    bit killed;
    nwords   = vfy ? 2 * NW : NW;
    w        = 0;
    wb       = 0;
    gap_left = gap ? 5 : 0;
    done_cyc = -1;
    we_cyc   = 0;
    killed   = 1'b0;

    @(negedge clk);
    start  = 1'b1;
    verify = vfy;
    abort  = with_abort;
    @(negedge clk);
    start  = 1'b0;
    abort  = 1'b0;
    c      = 1;
    check("busy_after_start", busy, 1);
    check("ready_after_start", wr_ready, 1);
    check("err_cleared", err, 0);
    check("err_cnt_cleared", err_cnt, 0);

    while (c < 1000 && done_cyc < 0 && !killed) begin
      wr_valid = 1'b0;
      // a start pulse mid-run must be ignored
      start = (c == 20);
      if (cfg_we) begin
        we_cyc++;
        wb++;
      end
      if (done) begin
        done_cyc = c;
      end else if (kill_w >= 0 && w == kill_w + 1 && wb == 8) begin
        killed = 1'b1;
        start  = 1'b0;
        if (kill_rst) begin
          #2 rstb = 1'b0;
          #1;
          check("rst_we_async", cfg_we, 0);
          check("rst_busy", busy, 0);
          @(negedge clk);
          rstb = 1'b1;
        end else begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_we", cfg_we, 0);
          check("abort_busy", busy, 0);
          check("abort_ready", wr_ready, 0);
          check("abort_no_done", done, 0);
        end
      end else if (wr_ready && w < nwords) begin
        if (w == 3 && gap_left > 0) begin
          check("gap_we_low", cfg_we, 0);
          gap_left--;
        end else begin
          wr_valid = 1'b1;
          wr_data  = word_val(w / NW, w % NW, mode);
          exp_q.push_back(wr_data);
          w++;
          wb = 0;
        end
      end
      if (done_cyc < 0 && !killed) begin
        @(negedge clk);
        c++;
      end
    end
    wr_valid = 1'b0;
    start    = 1'b0;

    if (!killed) begin
      check("done_seen", done_cyc >= 0, 1);
      @(negedge clk);
      check("done_single_pulse", done, 0);
      check("idle_after_done", busy, 0);
    end else begin
      // let the monitor discard the cut-short word, then forget it
      @(negedge clk);
      void'(exp_q.pop_back());
    end
    drain_sb();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int dc;
  int we;

  initial begin
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_we", cfg_we, 0);
    rstb = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ready", wr_ready, 0);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_cfg_we", cfg_we, 0);
    check("idle_cfg_d", cfg_d, 0);
    check("idle_state", dbg_state, 0);

    // Load only
    run_load(1'b0, 0, 1'b0, 1'b0, -1, 1'b0, dc, we);
    check("load_done_cyc", dc, 137);
    check("load_we_cyc", we, 128);
    check("load_err", err, 0);
    check("load_tail", chain[CFG_LEN-1 -: W], 16'hA5F0);
    check("load_chain", chain, chain_img(0, 0));

    // Verify, clean (start raised together with abort in IDLE)
    run_load(1'b1, 0, 1'b0, 1'b1, -1, 1'b0, dc, we);
    check("vclean_done_cyc", dc, 273);
    check("vclean_we_cyc", we, 256);
    check("vclean_err", err, 0);
    check("vclean_err_cnt", err_cnt, 0);
    check("vclean_chain", chain, chain_img(0, 0));

    // Verify, one corrupted bit
    run_load(1'b1, 1, 1'b0, 1'b0, -1, 1'b0, dc, we);
    check("vcorrupt_done_cyc", dc, 273);
    check("vcorrupt_err", err, 1);
    check("vcorrupt_err_cnt", err_cnt, 1);

    // Verify, inverted second pass
    run_load(1'b1, 2, 1'b0, 1'b0, -1, 1'b0, dc, we);
    check("vinvert_err", err, 1);
    check("vinvert_err_cnt", err_cnt, 128);
    check("vinvert_chain", chain, chain_img(1, 2));

    // Backpressure (its start must clear the errors left above)
    run_load(1'b0, 0, 1'b1, 1'b0, -1, 1'b0, dc, we);
    check("bp_done_cyc", dc, 142);
    check("bp_we_cyc", we, 128);
    check("bp_err", err, 0);
    check("bp_chain", chain, chain_img(0, 0));

    // Abort in the verify pass, word 4, after a corrupted word 3
    run_load(1'b1, 1, 1'b0, 1'b0, NW + 4, 1'b0, dc, we);
    check("abort_done_absent", dc < 0, 1);
    check("abort_err_held", err, 1);
    check("abort_err_cnt_held", err_cnt, 1);
    check("abort_state", dbg_state, 0);

    // Reset mid-shift on word 4
    run_load(1'b0, 0, 1'b0, 1'b0, 4, 1'b0 | 1'b1, dc, we);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_err_cnt", err_cnt, 0);

    // Full load after reset completes normally
    run_load(1'b0, 0, 1'b0, 1'b0, -1, 1'b0, dc, we);
    check("reload_done_cyc", dc, 137);
    check("reload_we_cyc", we, 128);
    check("reload_chain", chain, chain_img(0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
